// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI slave transaction controller.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        WR_DATA   = 3'd2,
        WR_COMMIT = 3'd3,
        RD_LOAD   = 3'd4,
        RD_SHIFT  = 3'd5
    } state_e;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Bits needed to hold any per-phase edge count.
    function automatic int cnt_width(input int a, input int d);
        int m;
        m = (a > d) ? a : d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_bit_cnt.sv
// Loadable / clearable down-counter; o_tc flags the last edge of a phase.
module spi_bit_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/spi_ctrl_fsm.sv
// SPI slave transaction controller: address capture, R/W decode, write commit, read load/shift.
// Define SPI_CTRL_BURST_EN for burst transfers with address auto-increment.
module spi_ctrl_fsm
    import spi_ctrl_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic cs,
    input  logic sout,
    output logic miso_buff,
    output logic dm_we,
    output logic addr_we,
    output logic sr_we,
    output logic addr_inc,
    output logic xfer_done
);

    localparam int CNT_W = cnt_width(ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);

    state_e           r_state, w_state_nxt;
    logic             r_miso, r_dm, r_addr, r_sr, r_inc, r_done;
    logic             w_miso, w_dm, w_addr, w_sr, w_inc, w_done;
    logic             w_clr, w_load, w_dec, w_tc;
    logic [CNT_W-1:0] w_load_val;

    spi_bit_cnt #(.W(CNT_W)) u_cnt (
        .clk        (sclk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_tc       (w_tc)
    );

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            {r_miso, r_dm, r_addr, r_sr, r_inc, r_done} <= '0;
        end else begin
            r_state <= w_state_nxt;
            {r_miso, r_dm, r_addr, r_sr, r_inc, r_done} <=
                {w_miso, w_dm, w_addr, w_sr, w_inc, w_done};
        end
    end

    // Counter is reloaded with (edges-1) when entering a counted phase, cleared otherwise.
    always_comb begin
        w_state_nxt = r_state;
        {w_miso, w_dm, w_addr, w_sr, w_inc, w_done} = '0;
        w_clr      = 1'b0;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        if (cs) begin
            w_state_nxt = IDLE;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = ADDR;
                    w_load      = 1'b1;
                    w_load_val  = A_LAST;
                end
                ADDR: begin
                    w_addr = 1'b1;
                    if (w_tc) begin
                        if (sout == READ) begin
                            w_state_nxt = RD_LOAD;
                            w_clr       = 1'b1;
                        end else begin
                            w_state_nxt = WR_DATA;
                            w_load      = 1'b1;
                            w_load_val  = D_LAST;
                        end
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                WR_DATA: begin
                    if (w_tc) begin
                        w_state_nxt = WR_COMMIT;
                        w_clr       = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                WR_COMMIT: begin
                    w_dm   = 1'b1;
                    w_done = 1'b1;
`ifdef SPI_CTRL_BURST_EN
                    w_inc       = 1'b1;
                    w_state_nxt = WR_DATA;
                    w_load      = 1'b1;
                    w_load_val  = D_LAST;
`else
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
`endif
                end
                RD_LOAD: begin
                    w_sr        = 1'b1;
                    w_state_nxt = RD_SHIFT;
                    w_load      = 1'b1;
                    w_load_val  = D_LAST;
                end
                RD_SHIFT: begin
                    w_miso = 1'b1;
                    if (w_tc) begin
                        w_done = 1'b1;
                        w_clr  = 1'b1;
`ifdef SPI_CTRL_BURST_EN
                        w_inc       = 1'b1;
                        w_state_nxt = RD_LOAD;
`else
                        w_state_nxt = IDLE;
`endif
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
                end
            endcase
        end
    end

    assign miso_buff = r_miso;
    assign dm_we     = r_dm;
    assign addr_we   = r_addr;
    assign sr_we     = r_sr;
    assign addr_inc  = r_inc;
    assign xfer_done = r_done;

endmodule

// File: tb/tb_spi_ctrl_fsm.sv
// Directed bench for spi_ctrl_fsm: default widths plus a 15/16-bit instance.
module tb_spi_ctrl_fsm;

    // Output vector layout: {miso_buff, dm_we, addr_we, sr_we, addr_inc, xfer_done}
    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] AW = 6'b001000;
    localparam logic [5:0] SR = 6'b000100;
    localparam logic [5:0] MI = 6'b100000;
    localparam logic [5:0] DM = 6'b010001;
    localparam logic [5:0] MD = 6'b100001;
`ifdef SPI_CTRL_BURST_EN
    localparam logic [5:0] INC = 6'b000010;
`else
    localparam logic [5:0] INC = 6'b000000;
`endif

    logic sclk = 1'b0;
    logic rst_n, cs1, cs2, sout;
    logic m1, d1, a1, s1, i1, x1;
    logic m2, d2, a2, s2, i2, x2;
    logic [5:0] out1, out2;
    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    assign out1 = {m1, d1, a1, s1, i1, x1};
    assign out2 = {m2, d2, a2, s2, i2, x2};

    spi_ctrl_fsm u_dut1 (
        .sclk(sclk), .rst_n(rst_n), .cs(cs1), .sout(sout),
        .miso_buff(m1), .dm_we(d1), .addr_we(a1), .sr_we(s1),
        .addr_inc(i1), .xfer_done(x1)
    );

    spi_ctrl_fsm #(.ADDR_W(15), .DATA_W(16)) u_dut2 (
        .sclk(sclk), .rst_n(rst_n), .cs(cs2), .sout(sout),
        .miso_buff(m2), .dm_we(d2), .addr_we(a2), .sr_we(s2),
        .addr_inc(i2), .xfer_done(x2)
    );

    task automatic step(input bit which, input logic s, input logic [5:0] exp, input string tag);
        logic [5:0] obs;
        sout = s;
        @(posedge sclk);
        #1;
        obs = which ? out2 : out1;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%b expected=%b", tag, which + 1, obs, exp);
        end
    endtask

    task automatic set_cs(input bit which, input logic v);
        if (which) cs2 = v;
        else       cs1 = v;
    endtask

    // E0..EA: idle edge, then address bits with alternating sout, R/W flag last.
    task automatic do_addr(input bit which, input int aw, input logic rd);
        set_cs(which, 1'b0);
        step(which, 1'b1, Z, "idle_e0");
        for (int i = 1; i < aw; i++) step(which, i[0], AW, "addr");
        step(which, rd, AW, "addr_rw");
    endtask

    task automatic do_write(input bit which, input int aw, input int dw);
        do_addr(which, aw, 1'b0);
        for (int i = 0; i < dw; i++) step(which, i[0], Z, "wr_data");
        step(which, 1'b0, DM | INC, "wr_commit");
    endtask

    task automatic do_read(input bit which, input int aw, input int dw);
        do_addr(which, aw, 1'b1);
        step(which, 1'b0, SR, "rd_load");
        for (int i = 1; i < dw; i++) step(which, i[0], MI, "rd_shift");
        step(which, 1'b0, MD | INC, "rd_last");
    endtask

    task automatic cs_off(input bit which);
        set_cs(which, 1'b1);
        step(which, 1'b0, Z, "cs_idle");
    endtask

    initial begin
        rst_n = 1'b0; cs1 = 1'b0; cs2 = 1'b1; sout = 1'b0;
        step(0, 1'b0, Z, "reset_cs_low");
        step(0, 1'b0, Z, "reset_hold");
        rst_n = 1'b1;

        // Write, default widths; cs stays low so the controller re-enters ADDR.
        do_write(0, 7, 8);
`ifndef SPI_CTRL_BURST_EN
        step(0, 1'b0, Z,  "restart_idle");
        step(0, 1'b0, AW, "restart_addr");
`endif
        cs_off(0);

        // Read, default widths.
        do_read(0, 7, 8);
        cs_off(0);

        // Abort during address phase, then a clean write.
        do_addr(0, 4, 1'b0);
        cs_off(0);
        step(0, 1'b0, Z, "abort_hold");
        do_write(0, 7, 8);
        cs_off(0);

        // Reset mid-read at E11, cs held low throughout.
        do_addr(0, 7, 1'b1);
        step(0, 1'b0, SR, "rd_load");
        step(0, 1'b0, MI, "rd_e9");
        step(0, 1'b0, MI, "rd_e10");
        rst_n = 1'b0;
        step(0, 1'b0, Z, "rst_mid_e11");
        step(0, 1'b0, Z, "rst_hold_cs_low");
        rst_n = 1'b1;
        step(0, 1'b0, Z,  "rst_rel_idle");
        step(0, 1'b0, AW, "rst_rel_addr");
        cs_off(0);

`ifdef SPI_CTRL_BURST_EN
        // Burst write of three words, then burst read of two-plus words.
        do_write(0, 7, 8);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) step(0, 1'b0, Z, "bw_data");
            step(0, 1'b0, DM | INC, "bw_commit");
        end
        cs_off(0);
        do_read(0, 7, 8);
        step(0, 1'b0, SR, "br_reload1");
        for (int i = 1; i < 8; i++) step(0, 1'b0, MI, "br_shift");
        step(0, 1'b0, MD | INC, "br_last2");
        step(0, 1'b0, SR, "br_reload2");
        cs_off(0);
`endif

        // Wide instance: 15 address bits, 16 data bits.
        cs1 = 1'b1;
        do_write(1, 15, 16);
        cs_off(1);
        do_read(1, 15, 16);
        cs_off(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
